pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter sequencer at the front of the fetch path. It owns the 8-bit PC register.
- It consumes the branch target produced by the branch-address adder (BrA = PC + offset), which is computed from this block's own PC output.
- Each enabled cycle it selects the next PC from: increment, branch target, absolute jump, call, or return.
- It holds a small hardware return-address stack and a RUN/HALT state machine.

Parameters:
- AW, 8, address width of PC, BrA, jump_addr and stack entries.
- DEPTH, 4, number of return-address stack entries (power of two, at least 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, all state held.
- halt  in  1  request to enter HALT.
- resume  in  1  request to leave HALT.
- branch_taken  in  1  conditional branch resolved taken.
- BrA  in  AW  branch target from the branch adder.
- jump  in  1  unconditional absolute jump.
- call  in  1  subroutine call; target is jump_addr.
- ret  in  1  subroutine return.
- jump_addr  in  AW  absolute target for jump and call.
- PC  out  AW  current program counter (registered).
- next_pc  out  AW  combinational value PC will take at the next edge.
- halted  out  1  1 while in HALT state (registered).
- stack_full  out  1  DEPTH entries in use.
- stack_empty  out  1  zero entries in use.
- stack_err  out  1  sticky overflow/underflow flag; cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - PC=0, state=RUN, stack pointer=0, stack_err=0.
  - Resulting outputs: halted=0, stack_empty=1, stack_full=0.
  - rst overrides every other input, including mid-halt and mid-call.
  - Stack contents are don't-care after reset.
- FSM, two states:
  - RUN: halt=1 and en=1 -> HALT. PC is held that cycle and the halt cycle performs no PC update.
  - HALT: resume=1 -> RUN, with PC unchanged on that edge. All control inputs other than resume and rst are ignored in HALT.
  - en=0 freezes the FSM as well.
- Next-PC selection in RUN with en=1 and halt=0. Priority is highest first; exactly one action is taken:
  1. ret:
     - Stack non-empty: pop; PC <= popped value.
     - Stack empty: stack_err <= 1; PC <= PC+1; pointer unchanged.
  2. call:
     - Stack not full: push PC+1; PC <= jump_addr.
     - Stack full: stack_err <= 1; no push; PC <= jump_addr anyway.
  3. jump: PC <= jump_addr.
  4. branch_taken: PC <= BrA.
  5. Otherwise: PC <= PC+1.
- Simultaneous requests: lower-priority requests are dropped silently. For example, ret+call performs only the ret, with no push.
- Arithmetic and widths:
  - PC+1 is modulo 2^AW: 8'hFF -> 8'h00.
  - A pushed return address of PC=8'hFF is 8'h00.
  - No carry output.
- next_pc:
  - Equals the value the PC register will load at the next edge under the current inputs.
  - Equals PC when rst=0 and the block is stalled, halted, or processing halt/resume.
  - Equals 0 when rst=1.
- Stack:
  - LIFO; the pointer counts 0..DEPTH.
  - stack_full = (pointer==DEPTH); stack_empty = (pointer==0). Both derive from the registered pointer.
- Latency:
  - PC updates one cycle after inputs are sampled.
  - BrA is used in the same cycle it is presented; no internal registering of BrA.

Test Plan:
- Reset and increment: rst=1 for 2 cycles, then en=1 with no controls for 3 cycles -> PC=00, 01, 02, 03; halted=0; stack_empty=1.
- Wrap and branch:
  - With PC=FE, idle for 2 cycles -> PC=FF then 00.
  - With PC=10, branch_taken=1, BrA=0x25 -> next edge PC=25; next_pc=25 during that cycle.
- Call/return nesting:
  - At PC=05, call with jump_addr=40 -> PC=40.
  - At PC=40, call with jump_addr=80 -> PC=80.
  - ret -> PC=41; ret -> PC=06; stack_empty=1; stack_err=0.
- Overflow/underflow:
  - 5 consecutive calls with jump_addr=20 (DEPTH=4) -> stack_full=1 after the 4th call; stack_err=1 after the 5th; PC=20.
  - After rst, ret on an empty stack at PC=30 -> PC=31, stack_err=1 and sticky until rst.
- Priority:
  - At PC=50, assert ret+call+jump+branch_taken with the stack holding 0x12 -> PC=12, pointer decremented, no push.
  - Then jump=1, jump_addr=0x70, branch_taken=1, BrA=0x33 -> PC=70.
- Stall, halt, reset mid-halt:
  - en=0 for 3 cycles at PC=08 -> PC stays 08 while branch_taken is asserted.
  - halt at PC=08 -> halted=1, PC=08 held for 4 cycles despite jump.
  - resume -> halted=0, PC=08; next idle edge -> PC=09.
  - Separately, rst while halted -> PC=00, halted=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, picks the next fetch address each enabled cycle,
// and keeps a small return-address stack plus a RUN/HALT state machine.
module pc_sequencer #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          halt,
  input  logic          resume,
  input  logic          branch_taken,
  input  logic [AW-1:0] BrA,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] next_pc,
  output logic          halted,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          stack_err
);

  // Pointer counts 0..DEPTH inclusive, so it needs one more bit than the entry index.
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic {StRun, StHalt} state_e;

  state_e        stateQ, stateD;
  logic [AW-1:0] pcQ, pcD, pcInc;
  logic [PW-1:0] spQ, spD, spDec;
  logic          errQ, errD;
  logic          doPush;
  logic [AW-1:0] stack [DEPTH];

  assign pcInc = pcQ + AW'(1);
  assign spDec = spQ - PW'(1);

  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    spD    = spQ;
    errD   = errQ;
    doPush = 1'b0;
    if (en) begin
      case (stateQ)
        StRun: begin
          if (halt) begin
            stateD = StHalt;
          end else if (ret) begin
            if (stack_empty) begin
              errD = 1'b1;
              pcD  = pcInc;
            end else begin
              spD = spDec;
              pcD = stack[spDec[IW-1:0]];
            end
          end else if (call) begin
            // The call still redirects on overflow; only the push is lost.
            pcD = jump_addr;
            if (stack_full) begin
              errD = 1'b1;
            end else begin
              doPush = 1'b1;
              spD    = spQ + PW'(1);
            end
          end else if (jump) begin
            pcD = jump_addr;
          end else if (branch_taken) begin
            pcD = BrA;
          end else begin
            pcD = pcInc;
          end
        end
        StHalt: begin
          if (resume) stateD = StRun;
        end
        default: stateD = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StRun;
      pcQ    <= '0;
      spQ    <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
      spQ    <= spD;
      errQ   <= errD;
    end
  end

  // Stack contents are not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (!rst && doPush) stack[spQ[IW-1:0]] <= pcInc;
  end

  assign PC          = pcQ;
  assign next_pc     = rst ? '0 : pcD;
  assign halted      = (stateQ == StHalt);
  assign stack_full  = (spQ == PW'(DEPTH));
  assign stack_empty = (spQ == '0);
  assign stack_err   = errQ;

endmodule
